// File: rtl/poly_noise_sampler.sv
// -----------------------------------------------------------------------------
// poly_noise_sampler
//
// Noise-polynomial generator for encapsulation. A request captures a 256-bit
// seed and a base nonce. For each of K polynomials the block then:
//   1. asks an external SHAKE core for a PRF stream of 512*ETA bits, using the
//      message {coins, nonce};
//   2. runs the stream through a centered binomial distribution (CBD) of
//      width ETA, LANES coefficients per cycle;
//   3. presents the 256-coefficient polynomial on a valid/ready handshake.
// The nonce increments (mod 256) after every accepted polynomial.
//
// Optional feature macro: NOISE_MODQ_EN
//   undefined : COEF_W = 4,  coefficient c emitted as 4-bit two's complement
//   defined   : COEF_W = 12, coefficient emitted as c (c >= 0) or 3329 + c
//
// Parameters
//   K      polynomials per request (1..4)
//   ETA    CBD parameter (2 or 3)
//   LANES  coefficients sampled per cycle (power of two, 1..32)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   start       request pulse, accepted only while busy = 0
//   coins       256-bit seed, captured on an accepted start
//   nonce_base  first nonce, captured on an accepted start
//   busy        high from accepted start until the cycle after done
//   sh_start    one-cycle request to the SHAKE core
//   sh_msg      {coins, nonce}, held stable for the whole request
//   sh_out_len  requested stream length in bits (512*ETA)
//   sh_done     SHAKE result valid, only looked at while waiting for it
//   sh_stream   SHAKE output, bit 0 first
//   poly_valid  poly_out / poly_idx valid
//   poly_ready  consumer accepts the current polynomial
//   poly_idx    index 0..K-1 of the current polynomial
//   poly_out    coefficient i at [COEF_W*i +: COEF_W]
//   done        one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module poly_noise_sampler #(
  parameter int K     = 3,
  parameter int ETA   = 2,
  parameter int LANES = 8,
`ifdef NOISE_MODQ_EN
  localparam int COEF_W = 12
`else
  localparam int COEF_W = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [255:0]            coins,
  input  logic [7:0]              nonce_base,
  output logic                    busy,
  output logic                    sh_start,
  output logic [263:0]            sh_msg,
  output logic [13:0]             sh_out_len,
  input  logic                    sh_done,
  input  logic [1535:0]           sh_stream,
  output logic                    poly_valid,
  input  logic                    poly_ready,
  output logic [1:0]              poly_idx,
  output logic [256*COEF_W-1:0]   poly_out,
  output logic                    done
);

  localparam int STREAM_W = 1536;
  localparam int NCYC     = 256 / LANES;       // CBD cycles per polynomial
  localparam int CNT_W    = $clog2(NCYC);
  localparam int STEP     = 2 * ETA * LANES;   // stream bits consumed per cycle
  localparam int PW       = 256 * COEF_W;
  localparam int LW       = LANES * COEF_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CBD,
    ST_OUT,
    ST_FIN
  } state_t;

  state_t              state_q, state_d;
  logic [255:0]        coins_q, coins_d;
  logic [7:0]          nonce_q, nonce_d;
  logic [1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STREAM_W-1:0] stream_q, stream_d;
  logic [PW-1:0]       poly_q, poly_d;

  // Coefficients produced this cycle from the low STEP bits of the buffer.
  logic [LW-1:0]       lane_coef;

  // ---------------------------------------------------------------------------
  // CBD lanes. The stream buffer shifts down by STEP bits per cycle, so lane l
  // always reads its 2*ETA bits from a fixed position at the bottom.
  // ---------------------------------------------------------------------------
  always_comb begin : cbd_lanes
    logic [2:0] a;
    logic [2:0] b;
    lane_coef = '0;
    for (int l = 0; l < LANES; l++) begin
      a = '0;
      b = '0;
      for (int e = 0; e < ETA; e++) begin
        a = a + 3'(stream_q[2*ETA*l + e]);
        b = b + 3'(stream_q[2*ETA*l + ETA + e]);
      end
`ifdef NOISE_MODQ_EN
      // Map [-ETA, ETA] into [0, q) with q = 3329.
      lane_coef[COEF_W*l +: COEF_W] = (a >= b) ? 12'(a - b) : 12'd3329 - 12'(b - a);
`else
      // Modular 4-bit subtraction yields the two's-complement encoding directly.
      lane_coef[COEF_W*l +: COEF_W] = 4'(a) - 4'(b);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every next-state value is defaulted to its current value first, so
    // branches that do not touch a register cannot infer a latch.
    state_d  = state_q;
    coins_d  = coins_q;
    nonce_d  = nonce_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    stream_d = stream_q;
    poly_d   = poly_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          coins_d = coins;
          nonce_d = nonce_base;
          idx_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // The whole stream port is captured; only the low 512*ETA bits ever
        // reach the lanes before the polynomial is complete.
        if (sh_done) begin
          stream_d = sh_stream;
          cnt_d    = '0;
          state_d  = ST_CBD;
        end
      end

      ST_CBD: begin
        stream_d = stream_q >> STEP;
        // New lanes enter at the top; after NCYC cycles the first group has
        // reached coefficient 0.
        poly_d   = {lane_coef, poly_q[PW-1:LW]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCYC - 1)) begin
          state_d = ST_OUT;
        end
      end

      ST_OUT: begin
        if (poly_ready) begin
          nonce_d = nonce_q + 8'd1;
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'(K - 1)) ? ST_FIN : ST_REQ;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      coins_q  <= '0;
      nonce_q  <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      // NOTE: the wide stream and polynomial buffers are cleared as well, so
      // an aborted request leaves nothing visible on poly_out or sh_msg.
      stream_q <= '0;
      poly_q   <= '0;
    end else begin
      state_q  <= state_d;
      coins_q  <= coins_d;
      nonce_q  <= nonce_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      stream_q <= stream_d;
      poly_q   <= poly_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from registers only, so poly_ready never reaches
  // poly_valid combinationally.
  // ---------------------------------------------------------------------------
  assign busy       = (state_q != ST_IDLE);
  assign sh_start   = (state_q == ST_REQ);
  assign poly_valid = (state_q == ST_OUT);
  assign done       = (state_q == ST_FIN);
  assign poly_idx   = idx_q;
  assign poly_out   = poly_q;
  assign sh_msg     = {coins_q, nonce_q};
  assign sh_out_len = 14'(512 * ETA);

endmodule
